mips_multicycle_control: RTL and testbench
==========================================

MIPS_MULTICYCLE_CONTROL -- requirements
Module: mips_multicycle_control

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low reset (0 = reset).
REQ-003 SHALL have ports: op  in  6  Instr[31:26]; funct  in  6  Instr[5:0]; mem_ready  in  1  memory completes current access this cycle.
REQ-004 SHALL have ports: IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, Branch, PCWrite  out  1  each  datapath enables/selects.
REQ-005 SHALL have ports: ALUSrcB  out  2  (00 RD2, 01 const 4, 10 SignImm, 11 SignImm<<2); PCSrc  out  2  (00 ALUResult, 01 ALUOut, 10 jump target); ALUControl  out  3.
REQ-006 SHALL have ports: state  out  4  current state code; illegal_op  out  1  sticky unsupported-opcode flag; instr_done  out  1  one-cycle retire pulse.

Function
REQ-007 SHALL implement a Moore FSM with codes FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; codes 12-15 SHALL go to FETCH next cycle with all enables 0.
REQ-008 FETCH: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUControl=010, PCSrc=00; IRWrite=PCWrite=1 only in the cycle mem_ready=1; stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
REQ-009 DECODE: ALUSrcA=0, ALUSrcB=11, ALUControl=010, no write enables; next by op: 100011/101011->MEMADR, 000000->EXECUTE, 000100->BRANCH, 001000->ADDIEX, 000010->JUMP, other->FETCH with illegal_op set.
REQ-010 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUControl=010; next MEMREAD if op=100011, else MEMWRITE.
REQ-011 MEMREAD: IorD=1, MemRead=1; holds until mem_ready=1, then MEMWB.
REQ-012 MEMWRITE: IorD=1, MemWrite=1 every cycle until mem_ready=1; then FETCH with instr_done=1 in that final cycle.
REQ-013 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1; next FETCH.
REQ-014 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUControl from funct (100000->010, 100010->110, 100100->000, 100101->001, 101010->111, other->010 and illegal_op set); next ALUWB.
REQ-015 ALUWB: RegDst=1, MemtoReg=0, RegWrite=1, instr_done=1; next FETCH.
REQ-016 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=110, Branch=1, PCSrc=01, instr_done=1; next FETCH (PC update gated externally by Branch&Zero).
REQ-017 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUControl=010; next ADDIWB. ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, instr_done=1; next FETCH.
REQ-018 JUMP: PCSrc=10, PCWrite=1, instr_done=1; next FETCH.
REQ-019 Every output not listed for a state SHALL be 0; outputs SHALL depend only on state, funct and mem_ready (no op-dependent outputs outside DECODE/MEMADR transitions).
REQ-020 MemRead and MemWrite SHALL never be 1 in the same cycle; at most one of RegWrite/PCWrite/IRWrite/MemWrite pairs per REQ-008..018.
REQ-021 illegal_op SHALL stay 1 until reset; an illegal instruction SHALL retire no writes and emit no instr_done.

Reset
REQ-022 reset=0 SHALL immediately (asynchronously) force state=FETCH, illegal_op=0 and all write enables (IRWrite, PCWrite, RegWrite, MemWrite) and instr_done to 0, regardless of mem_ready.
REQ-023 Reset asserted mid-instruction (any state, including stalled MEMWRITE) SHALL abandon it with no further writes; first fetch begins on the first rising edge with reset=1.

Verification
REQ-024 lw (op=100011), mem_ready=1 always -> states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4; instr_done one pulse.
REQ-025 sw (op=101011), mem_ready low 3 cycles in MEMWRITE -> state 5 held 4 cycles with MemWrite=1 each, then 0; RegWrite never 1.
REQ-026 R-type funct=100010 -> states 0,1,6,7,0; ALUControl=110 in state 6; RegDst=1, RegWrite=1 in state 7.
REQ-027 FETCH with mem_ready=0 for 2 cycles -> IRWrite=PCWrite=0 for 2 cycles, then 1 for exactly one cycle, state 0->1.
REQ-028 op=111111 -> states 0,1,0; illegal_op=1 thereafter; no RegWrite/MemWrite; cleared only by reset=0.
REQ-029 reset=0 pulsed between clock edges while in state 5 -> state=0 and MemWrite=0 immediately, before next edge.

Source files
------------

// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - Multicycle MIPS control unit (Moore FSM with memory handshake)
//
// Ports:
//   clk        in   1  rising-edge clock
//   reset      in   1  asynchronous active-low reset
//   op         in   6  Instr[31:26]
//   funct      in   6  Instr[5:0]
//   mem_ready  in   1  memory finishes the current access this cycle
//   IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
//   ALUSrcA, Branch, PCWrite  out 1  datapath enables/selects
//   ALUSrcB    out  2  00 RD2, 01 const 4, 10 SignImm, 11 SignImm<<2
//   PCSrc      out  2  00 ALUResult, 01 ALUOut, 10 jump target
//   ALUControl out  3  ALU operation
//   state      out  4  current state code
//   illegal_op out  1  sticky unsupported-instruction flag
//   instr_done out  1  one-cycle retire pulse

module mips_multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic       Branch,
    output logic       PCWrite,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUControl,
    output logic [3:0] state,
    output logic       illegal_op,
    output logic       instr_done
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t state_q;
    logic   illegal_q;

    // R-type function decode. An unsupported funct still executes an add
    // but is marked not-ok so the write-back cycle retires nothing.
    logic       funct_ok;
    logic [2:0] alu_rtype;

    always_comb begin
        funct_ok  = 1'b1;
        alu_rtype = ALU_ADD;
        case (funct)
            6'b100000: alu_rtype = ALU_ADD;
            6'b100010: alu_rtype = ALU_SUB;
            6'b100100: alu_rtype = ALU_AND;
            6'b100101: alu_rtype = ALU_OR;
            6'b101010: alu_rtype = ALU_SLT;
            default: begin
                alu_rtype = ALU_ADD;
                funct_ok  = 1'b0;
            end
        endcase
    end

    // State register and sticky illegal flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (mem_ready) state_q <= S_DECODE;
                end
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: state_q <= S_MEMADR;
                        OP_RTYPE:     state_q <= S_EXECUTE;
                        OP_BEQ:       state_q <= S_BRANCH;
                        OP_ADDI:      state_q <= S_ADDIEX;
                        OP_J:         state_q <= S_JUMP;
                        default: begin
                            state_q   <= S_FETCH;
                            illegal_q <= 1'b1;
                        end
                    endcase
                end
                S_MEMADR: begin
                    state_q <= (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                end
                S_MEMREAD: begin
                    if (mem_ready) state_q <= S_MEMWB;
                end
                S_MEMWRITE: begin
                    if (mem_ready) state_q <= S_FETCH;
                end
                S_EXECUTE: begin
                    if (!funct_ok) illegal_q <= 1'b1;
                    state_q <= S_ALUWB;
                end
                S_ADDIEX: state_q <= S_ADDIWB;
                S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_q <= S_FETCH;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // Moore outputs. They follow the state register combinationally so that
    // the handshake-qualified enables (IRWrite/PCWrite in FETCH, instr_done
    // in MEMWRITE) line up with the cycle mem_ready is seen, and so that an
    // asserted reset silences every output before the next edge.
    always_comb begin
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        Branch     = 1'b0;
        PCWrite    = 1'b0;
        ALUSrcB    = 2'b00;
        PCSrc      = 2'b00;
        ALUControl = 3'b000;
        instr_done = 1'b0;
        if (reset) begin
            case (state_q)
                S_FETCH: begin
                    MemRead    = 1'b1;
                    ALUSrcB    = 2'b01;
                    ALUControl = ALU_ADD;
                    IRWrite    = mem_ready;
                    PCWrite    = mem_ready;
                end
                S_DECODE: begin
                    ALUSrcB    = 2'b11;
                    ALUControl = ALU_ADD;
                end
                S_MEMADR: begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = 2'b10;
                    ALUControl = ALU_ADD;
                end
                S_MEMREAD: begin
                    IorD    = 1'b1;
                    MemRead = 1'b1;
                end
                S_MEMWB: begin
                    MemtoReg   = 1'b1;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEMWRITE: begin
                    IorD       = 1'b1;
                    MemWrite   = 1'b1;
                    instr_done = mem_ready;
                end
                S_EXECUTE: begin
                    ALUSrcA    = 1'b1;
                    ALUControl = alu_rtype;
                end
                S_ALUWB: begin
                    // funct is still held in the IR, so an unsupported
                    // R-type is suppressed here without an extra state.
                    RegDst     = 1'b1;
                    RegWrite   = funct_ok;
                    instr_done = funct_ok;
                end
                S_BRANCH: begin
                    ALUSrcA    = 1'b1;
                    ALUControl = ALU_SUB;
                    Branch     = 1'b1;
                    PCSrc      = 2'b01;
                    instr_done = 1'b1;
                end
                S_ADDIEX: begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = 2'b10;
                    ALUControl = ALU_ADD;
                end
                S_ADDIWB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_JUMP: begin
                    PCSrc      = 2'b10;
                    PCWrite    = 1'b1;
                    instr_done = 1'b1;
                end
                default: begin
                    IorD = 1'b0;
                end
            endcase
        end
    end

    assign state      = state_q;
    assign illegal_op = illegal_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb/tb_mips_multicycle_control.sv - Self-checking bench for mips_multicycle_control

module tb_mips_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       mem_ready;
    logic       IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
    logic       ALUSrcA, Branch, PCWrite;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUControl;
    logic [3:0] state;
    logic       illegal_op, instr_done;

    always #5 clk = ~clk;

    mips_multicycle_control dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .mem_ready(mem_ready),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .Branch(Branch), .PCWrite(PCWrite), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
        .ALUControl(ALUControl), .state(state), .illegal_op(illegal_op),
        .instr_done(instr_done)
    );

    logic [17:0] dut_vec;
    assign dut_vec = {IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                      ALUSrcA, Branch, PCWrite, ALUSrcB, PCSrc, ALUControl, instr_done};

    int n_checks = 0;
    int n_fail   = 0;

    int path_st[$];
    bit path_mr[$];
    bit model_ill;
    int n_cycles, n_irw, n_done, n_regw, n_memw, n_s5, n_s0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit op_legal(input logic [5:0] o);
        return (o == 6'b100011) || (o == 6'b101011) || (o == 6'b000000) ||
               (o == 6'b000100) || (o == 6'b001000) || (o == 6'b000010);
    endfunction

    function automatic bit funct_legal(input logic [5:0] f);
        return (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
               (f == 6'b100101) || (f == 6'b101010);
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] f);
        if (f == 6'b100010) return 3'b110;
        if (f == 6'b100100) return 3'b000;
        if (f == 6'b100101) return 3'b001;
        if (f == 6'b101010) return 3'b111;
        return 3'b010;
    endfunction

    // Expected output vector for one cycle, taken from the per-state table.
    function automatic logic [17:0] exp_out(input int st, input logic [5:0] f, input bit mr);
        logic iord, mrd, mwr, irw, rdst, m2r, rw, srca, br, pcw, done;
        logic [1:0] srcb, pcs;
        logic [2:0] aluc;
        {iord, mrd, mwr, irw, rdst, m2r, rw, srca, br, pcw, done} = '0;
        srcb = 2'b00; pcs = 2'b00; aluc = 3'b000;
        case (st)
            0:  begin mrd = 1; srcb = 2'b01; aluc = 3'b010; irw = mr; pcw = mr; end
            1:  begin srcb = 2'b11; aluc = 3'b010; end
            2:  begin srca = 1; srcb = 2'b10; aluc = 3'b010; end
            3:  begin iord = 1; mrd = 1; end
            4:  begin m2r = 1; rw = 1; done = 1; end
            5:  begin iord = 1; mwr = 1; done = mr; end
            6:  begin srca = 1; aluc = alu_of(f); end
            7:  begin rdst = 1; rw = funct_legal(f); done = funct_legal(f); end
            8:  begin srca = 1; aluc = 3'b110; br = 1; pcs = 2'b01; done = 1; end
            9:  begin srca = 1; srcb = 2'b10; aluc = 3'b010; end
            10: begin rw = 1; done = 1; end
            11: begin pcs = 2'b10; pcw = 1; done = 1; end
            default: ;
        endcase
        return {iord, mrd, mwr, irw, rdst, m2r, rw, srca, br, pcw, srcb, pcs, aluc, done};
    endfunction

    function automatic bit dcv(input bit r);
        return r ? bit'($urandom_range(0, 1)) : 1'b1;
    endfunction

    task automatic push(input int st, input bit mr);
        path_st.push_back(st);
        path_mr.push_back(mr);
    endtask

    // Sequence of states an instruction walks through, with stalls inserted.
    task automatic build_path(input logic [5:0] o, input int fstall, input int mstall, input bit r);
        path_st.delete();
        path_mr.delete();
        repeat (fstall) push(0, 1'b0);
        push(0, 1'b1);
        push(1, dcv(r));
        case (o)
            6'b100011: begin
                push(2, dcv(r));
                repeat (mstall) push(3, 1'b0);
                push(3, 1'b1);
                push(4, dcv(r));
            end
            6'b101011: begin
                push(2, dcv(r));
                repeat (mstall) push(5, 1'b0);
                push(5, 1'b1);
            end
            6'b000000: begin push(6, dcv(r)); push(7, dcv(r)); end
            6'b000100: push(8, dcv(r));
            6'b001000: begin push(9, dcv(r)); push(10, dcv(r)); end
            6'b000010: push(11, dcv(r));
            default: ;
        endcase
    endtask

    // Entered and left at posedge+1; checks every cycle at posedge+4.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int fstall,
                             input int mstall, input bit r, input int max_n);
        build_path(o, fstall, mstall, r);
        funct = f;
        n_cycles = 0; n_irw = 0; n_done = 0; n_regw = 0; n_memw = 0; n_s5 = 0; n_s0 = 0;
        for (int i = 0; i < path_st.size(); i++) begin
            if (max_n > 0 && i >= max_n) break;
            // op is not yet valid during fetch; outputs must ignore it.
            op = (path_st[i] == 0) ? 6'($urandom) : o;
            mem_ready = path_mr[i];
            #3;
            check($sformatf("state op=%b step%0d", o, i), 32'(state), 32'(path_st[i]));
            check($sformatf("outputs op=%b s%0d", o, path_st[i]), 32'(dut_vec),
                  32'(exp_out(path_st[i], f, path_mr[i])));
            check($sformatf("illegal_op op=%b s%0d", o, path_st[i]), 32'(illegal_op), 32'(model_ill));
            n_cycles++;
            n_irw  += int'(IRWrite);
            n_done += int'(instr_done);
            n_regw += int'(RegWrite);
            n_memw += int'(MemWrite);
            n_s5   += int'(state == 4'd5);
            n_s0   += int'(state == 4'd0);
            if (path_st[i] == 1 && !op_legal(o)) model_ill = 1'b1;
            if (path_st[i] == 6 && !funct_legal(f)) model_ill = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("reset state", 32'(state), 32'd0);
        check("reset illegal_op", 32'(illegal_op), 32'd0);
        check("reset enables", 32'({IRWrite, PCWrite, RegWrite, MemWrite, instr_done}), 32'd0);
        model_ill = 1'b0;
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        op = 6'd0;
        funct = 6'd0;
        mem_ready = 1'b1;
        model_ill = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // lw, memory always ready
        run_instr(6'b100011, 6'd0, 0, 0, 1'b0, 0);
        check("lw cycles", 32'(n_cycles), 32'd5);
        check("lw instr_done pulses", 32'(n_done), 32'd1);
        check("lw RegWrite cycles", 32'(n_regw), 32'd1);

        // sw with three stalled MEMWRITE cycles
        run_instr(6'b101011, 6'd0, 0, 3, 1'b0, 0);
        check("sw cycles in state 5", 32'(n_s5), 32'd4);
        check("sw MemWrite cycles", 32'(n_memw), 32'd4);
        check("sw RegWrite cycles", 32'(n_regw), 32'd0);

        // R-type sub
        run_instr(6'b000000, 6'b100010, 0, 0, 1'b0, 0);
        check("sub cycles", 32'(n_cycles), 32'd4);

        // fetch stalled two cycles
        run_instr(6'b100011, 6'd0, 2, 0, 1'b0, 0);
        check("stalled fetch cycles", 32'(n_s0), 32'd3);
        check("stalled fetch IRWrite cycles", 32'(n_irw), 32'd1);

        // remaining R-type functions and other instructions, random don't-care mem_ready
        run_instr(6'b000000, 6'b100000, 0, 0, 1'b1, 0);
        run_instr(6'b000000, 6'b100100, 1, 0, 1'b1, 0);
        run_instr(6'b000000, 6'b100101, 0, 0, 1'b1, 0);
        run_instr(6'b000000, 6'b101010, 0, 0, 1'b1, 0);
        run_instr(6'b000100, 6'b111111, 0, 0, 1'b1, 0);
        run_instr(6'b001000, 6'b101010, 0, 0, 1'b1, 0);
        run_instr(6'b000010, 6'b100010, 0, 0, 1'b1, 0);
        run_instr(6'b100011, 6'b000000, 1, 2, 1'b1, 0);
        run_instr(6'b101011, 6'b000000, 0, 0, 1'b1, 0);

        // unsupported funct: no write-back, flag set
        run_instr(6'b000000, 6'b000000, 0, 0, 1'b0, 0);
        check("bad funct RegWrite cycles", 32'(n_regw), 32'd0);
        check("bad funct instr_done pulses", 32'(n_done), 32'd0);
        check("bad funct illegal_op", 32'(illegal_op), 32'd1);
        do_reset();

        // unsupported opcode: 0,1,0 and sticky flag
        run_instr(6'b111111, 6'b100000, 0, 0, 1'b0, 0);
        check("illegal op cycles", 32'(n_cycles), 32'd2);
        check("illegal op writes", 32'(n_regw + n_memw + n_done), 32'd0);
        run_instr(6'b001000, 6'b000000, 0, 0, 1'b0, 0);
        check("illegal_op sticky", 32'(illegal_op), 32'd1);
        do_reset();
        check("illegal_op cleared", 32'(illegal_op), 32'd0);

        // sw abandoned by reset while stalled in MEMWRITE
        run_instr(6'b101011, 6'd0, 0, 5, 1'b0, 5);
        mem_ready = 1'b1;
        #2;
        check("pre-abort state", 32'(state), 32'd5);
        check("pre-abort MemWrite", 32'(MemWrite), 32'd1);
        reset = 1'b0;
        #1;
        check("abort state", 32'(state), 32'd0);
        check("abort MemWrite", 32'(MemWrite), 32'd0);
        check("abort enables", 32'({IRWrite, PCWrite, RegWrite, instr_done}), 32'd0);
        mem_ready = 1'b0;
        #1;
        reset = 1'b1;
        model_ill = 1'b0;
        @(posedge clk);
        #1;
        check("post-abort state", 32'(state), 32'd0);

        // recovery after abort
        run_instr(6'b001000, 6'd0, 0, 0, 1'b0, 0);
        check("addi after abort cycles", 32'(n_cycles), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end expected end");
        $fatal(1);
    end

endmodule
